vmem_wbuf: RTL and testbench

//  Write buffer between the blit engine and the video memory write port. It absorbs

---
 rtl/vmem_wbuf.sv | 130 +++++++++++++
 tb/tb_vmem_wbuf.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_wbuf.sv
// ============================================================================
// Module   : vmem_wbuf
// Purpose  : In-order write buffer between the blit engine and video memory,
//            with early-warning back-pressure and an ack-driven drain stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vmem_wbuf #(
  parameter int BLIT_WIDTH      = 8,
  parameter int BLIT_ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [BLIT_ADDR_WIDTH-1:0] addr_in,
  input  logic [BLIT_WIDTH-1:0]      data_in,
  output logic                       w_ready,
  input  logic                       drain_en,
  output logic                       vm_we,
  output logic [BLIT_ADDR_WIDTH-1:0] vm_addr,
  output logic [BLIT_WIDTH-1:0]      vm_data,
  input  logic                       vm_ack,
  output logic [DEPTH_LOG2:0]        level,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int                C_DEPTH     = 2 ** DEPTH_LOG2;
  localparam int                C_ENTRY_W   = BLIT_ADDR_WIDTH + BLIT_WIDTH;
  localparam logic [DEPTH_LOG2:0] C_FULL      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_READY_MAX = C_FULL - (DEPTH_LOG2 + 1)'(2);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0] C_LVL_ZERO  = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [C_ENTRY_W-1:0]       r_mem [C_DEPTH];
  logic [DEPTH_LOG2-1:0]      r_wr_ptr;
  logic [DEPTH_LOG2-1:0]      r_rd_ptr;
  logic [DEPTH_LOG2:0]        r_level;
  logic                       r_overflow;
  logic [BLIT_ADDR_WIDTH-1:0] r_vm_addr;
  logic [BLIT_WIDTH-1:0]      r_vm_data;

  logic w_full;
  logic w_push;
  logic w_avail;
  logic w_pop;

  assign w_full  = (r_level == C_FULL);
  assign w_push  = we & ~w_full;
  // Pop uses the registered level, so a same-cycle push into an empty FIFO is not bypassed
  assign w_avail = (r_level != C_LVL_ZERO) & drain_en;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_avail) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (vm_ack) begin
          if (w_avail) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {addr_in, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_vm_addr  <= '0;
      r_vm_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        {r_vm_addr, r_vm_data} <= r_mem[r_rd_ptr];
        r_rd_ptr               <= r_rd_ptr + C_PTR_ONE;
      end
      r_level <= r_level + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
      // A fresh overflow takes priority over a simultaneous clear
      if (we && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign vm_we    = (r_state == ST_BUSY);
  assign vm_addr  = r_vm_addr;
  assign vm_data  = r_vm_data;
  assign level    = r_level;
  assign w_ready  = (r_level <= C_READY_MAX);
  assign empty    = (r_level == C_LVL_ZERO) & ~vm_we;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_vmem_wbuf.sv
// ============================================================================
// Module   : tb_vmem_wbuf
// Purpose  : Self-checking bench for vmem_wbuf against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vmem_wbuf;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [15:0] addr_in = '0;
  logic [7:0]  data_in = '0;
  logic        w_ready;
  logic        drain_en = 1'b0;
  logic        vm_we;
  logic [15:0] vm_addr;
  logic [7:0]  vm_data;
  logic        vm_ack = 1'b0;
  logic [4:0]  level;
  logic        empty;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  vmem_wbuf #(
    .BLIT_WIDTH      (8),
    .BLIT_ADDR_WIDTH (16),
    .DEPTH_LOG2      (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .w_ready  (w_ready),
    .drain_en (drain_en),
    .vm_we    (vm_we),
    .vm_addr  (vm_addr),
    .vm_data  (vm_data),
    .vm_ack   (vm_ack),
    .level    (level),
    .empty    (empty),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of buffered {addr,data}, plus the issued vmem write
  logic [23:0] m_q[$];
  bit          m_busy = 1'b0;
  bit          m_ovf  = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  int          retired = 0;
  int          accepted = 0;
  bit          bl_r1 = 1'b1;
  bit          bl_r2 = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (DEPTH - m_q.size()) >= 2;
  endfunction

  task automatic model_update();
    bit          do_pop;
    bit          do_push;
    logic [23:0] e;
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      do_pop  = drain_en && (m_q.size() > 0) && (!m_busy || vm_ack);
      do_push = we && (m_q.size() < DEPTH);
      if (we && !do_push) m_ovf = 1'b1;
      else if (clr_ovf)   m_ovf = 1'b0;
      if (m_busy && vm_ack) retired++;
      if (do_pop) begin
        e      = m_q.pop_front();
        m_addr = e[23:8];
        m_data = e[7:0];
        m_busy = 1'b1;
      end else if (m_busy && vm_ack) begin
        m_busy = 1'b0;
      end
      if (do_push) begin
        m_q.push_back({addr_in, data_in});
        accepted++;
      end
    end
  endtask

  task automatic compare_all();
    check("vm_we", 32'(vm_we), 32'(m_busy));
    check("level", 32'(level), 32'(m_q.size()));
    check("w_ready", 32'(w_ready), 32'(m_ready()));
    check("empty", 32'(empty), 32'((m_q.size() == 0) && !m_busy));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_busy) begin
      check("vm_addr", 32'(vm_addr), 32'(m_addr));
      check("vm_data", 32'(vm_data), 32'(m_data));
    end
  endtask

  // One clock: model and DUT both see the inputs that are stable at this edge
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    bl_r2 = bl_r1;
    bl_r1 = w_ready;
  endtask

  // Blitter write that honours w_ready as seen one cycle earlier
  task automatic blit(input bit want);
    we      = want && bl_r2;
    addr_in = 16'($urandom);
    data_in = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    we = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  int base;
  int nwr;
  int peak;

  initial begin
    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_w_ready", 32'(w_ready), 32'd1);

    // Reset while a write is pending with 5 entries buffered
    drain_en = 1'b1;
    vm_ack   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      blit(1'b1);
      cycle();
    end
    we = 1'b0;
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_vm_we", 32'(vm_we), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_vm_we", 32'(vm_we), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_w_ready", 32'(w_ready), 32'd1);
    bl_r1 = 1'b1;
    bl_r2 = 1'b1;

    // Eight sequential writes, full-rate drain
    vm_ack = 1'b1;
    base   = retired;
    for (int i = 0; i < 8; i++) begin
      we      = 1'b1;
      addr_in = 16'h0100 + 16'(i);
      data_in = 8'hA0 + 8'(i);
      cycle();
      if (i == 0) check("lat_vm_we_e", 32'(vm_we), 32'd0);
      if (i == 1) check("lat_vm_we_e1", 32'(vm_we), 32'd1);
    end
    idle_cycles(4);
    check("seq8_retired", 32'(retired - base), 32'd8);
    check("seq8_empty", 32'(empty), 32'd1);

    // Stalled vmem: fill to the top honouring w_ready, then release
    vm_ack = 1'b0;
    base   = retired;
    nwr    = 0;
    peak   = 0;
    for (int i = 0; i < 30; i++) begin
      blit(1'b1);
      if (we) nwr++;
      cycle();
      if (int'(level) > peak) peak = int'(level);
    end
    we = 1'b0;
    check("fill_peak", 32'(peak), 32'd16);
    check("fill_writes", 32'(nwr), 32'd17);
    check("fill_ovf", 32'(overflow), 32'd0);

    // Forced write while full is dropped; overflow beats a same-cycle clear
    we = 1'b1;
    cycle();
    check("force_ovf", 32'(overflow), 32'd1);
    check("force_level", 32'(level), 32'd16);
    clr_ovf = 1'b1;
    cycle();
    check("ovf_wins", 32'(overflow), 32'd1);
    we = 1'b0;
    cycle();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    vm_ack = 1'b1;
    idle_cycles(20);
    check("fill_retired", 32'(retired - base), 32'd17);
    check("fill_empty", 32'(empty), 32'd1);

    // drain_en dropped while busy: the issued write retires, nothing new issues
    vm_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blit(1'b1);
      cycle();
    end
    we       = 1'b0;
    vm_ack   = 1'b1;
    drain_en = 1'b0;
    idle_cycles(4);
    check("gate_vm_we", 32'(vm_we), 32'd0);
    check("gate_level", 32'(level), 32'd2);
    drain_en = 1'b1;
    idle_cycles(4);
    check("gate_empty", 32'(empty), 32'd1);

    // Randomized traffic
    base = retired;
    nwr  = accepted;
    for (int i = 0; i < 10000; i++) begin
      blit(1'($urandom_range(0, 1)));
      vm_ack   = ($urandom_range(0, 3) != 0);
      drain_en = ($urandom_range(0, 7) != 0);
      cycle();
    end
    we       = 1'b0;
    vm_ack   = 1'b1;
    drain_en = 1'b1;
    idle_cycles(25);
    check("rand_no_ovf", 32'(overflow), 32'd0);
    check("rand_balance", 32'(retired - base), 32'(accepted - nwr));
    check("rand_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
